// File: rtl/uart_sched_pkg.sv
// Shared types and sizing helpers for the UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  typedef enum logic {
    GRANT_ECHO,
    GRANT_MSG
  } grant_t;

  function automatic int unsigned cnt_width(input int unsigned byte_cycles);
    return $clog2(byte_cycles);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small first-word-fall-through byte FIFO with wrap-bit pointers.
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_sys,
  input  logic       sys_reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        rd_fire;
  logic        wr_fire;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign rd_fire = rd_en && !empty;
  assign wr_fire = wr_en && (!full || rd_fire);

  always_ff @(posedge clk_sys) begin
    if (sys_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_fire) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter between the echo FIFO and a
// message source, pacing issue to one byte per frame time.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned BYTE_CYCLES = 52080,
  parameter int unsigned ECHO_DEPTH  = 4
) (
  input  logic       clk_sys,
  input  logic       sys_reset,
  input  logic [7:0] echo_data_i,
  input  logic       echo_valid_i,
  input  logic [7:0] msg_data_i,
  input  logic       msg_valid_i,
  output logic       msg_ready_o,
  output logic [7:0] uart_tx_data_o,
  output logic       uart_tx_en_o,
  output logic       busy_o,
  output logic       echo_overflow_o
);

  localparam int unsigned   CW       = cnt_width(BYTE_CYCLES);
  localparam logic [CW-1:0] GAP_LOAD = CW'(BYTE_CYCLES - 2);
  localparam logic [CW-1:0] GAP_LAST = CW'(1);

  state_t        state;
  state_t        state_nxt;
  grant_t        last_grant;
  grant_t        last_grant_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [7:0]    tx_data_nxt;
  logic          tx_en_nxt;
  logic          busy_nxt;
  logic          overflow_nxt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_rd;
  logic          fifo_wr;
  logic [7:0]    fifo_data;
  logic          echo_win;
  logic          msg_win;

  byte_fifo #(
    .DEPTH(ECHO_DEPTH)
  ) u_echo_fifo (
    .clk_sys  (clk_sys),
    .sys_reset(sys_reset),
    .wr_en    (fifo_wr),
    .wr_data  (echo_data_i),
    .rd_en    (fifo_rd),
    .rd_data  (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Round-robin pick: on a tie the source not granted last time wins.
  always_comb begin
    echo_win = !fifo_empty && (!msg_valid_i || last_grant == GRANT_MSG);
    msg_win  = msg_valid_i && !echo_win;
  end

  assign msg_ready_o  = (state == IDLE) && msg_win;
  assign fifo_rd      = (state == IDLE) && echo_win;
  assign fifo_wr      = echo_valid_i && (!fifo_full || fifo_rd);
  assign overflow_nxt = echo_overflow_o || (echo_valid_i && fifo_full && !fifo_rd);

  always_ff @(posedge clk_sys) begin
    if (sys_reset) begin
      state           <= IDLE;
      last_grant      <= GRANT_MSG;
      cnt             <= '0;
      uart_tx_data_o  <= 8'h00;
      uart_tx_en_o    <= 1'b0;
      busy_o          <= 1'b0;
      echo_overflow_o <= 1'b0;
    end else begin
      state           <= state_nxt;
      last_grant      <= last_grant_nxt;
      cnt             <= cnt_nxt;
      uart_tx_data_o  <= tx_data_nxt;
      uart_tx_en_o    <= tx_en_nxt;
      busy_o          <= busy_nxt;
      echo_overflow_o <= overflow_nxt;
    end
  end

  // GAP lasts BYTE_CYCLES-2 cycles so grants are exactly BYTE_CYCLES apart.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    tx_data_nxt    = uart_tx_data_o;
    tx_en_nxt      = 1'b0;
    busy_nxt       = busy_o;
    case (state)
      IDLE: begin
        if (echo_win || msg_win) begin
          state_nxt      = SEND;
          tx_en_nxt      = 1'b1;
          busy_nxt       = 1'b1;
          tx_data_nxt    = echo_win ? fifo_data : msg_data_i;
          last_grant_nxt = echo_win ? GRANT_ECHO : GRANT_MSG;
        end
      end
      SEND: begin
        state_nxt = GAP;
        cnt_nxt   = GAP_LOAD;
      end
      GAP: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler with a time-based reference model.
module tb_uart_tx_scheduler;

  localparam int B = 8;
  localparam int D = 4;
  localparam int P_EN   = 0;
  localparam int P_DATA = 1;
  localparam int P_BUSY = 2;
  localparam int P_OVF  = 3;
  localparam int P_RDY  = 4;

  logic       clk_sys = 1'b0;
  logic       sys_reset;
  logic [7:0] echo_data_i;
  logic       echo_valid_i;
  logic [7:0] msg_data_i;
  logic       msg_valid_i;
  logic       msg_ready_o;
  logic [7:0] uart_tx_data_o;
  logic       uart_tx_en_o;
  logic       busy_o;
  logic       echo_overflow_o;

  uart_tx_scheduler #(
    .BYTE_CYCLES(B),
    .ECHO_DEPTH (D)
  ) dut (
    .clk_sys        (clk_sys),
    .sys_reset      (sys_reset),
    .echo_data_i    (echo_data_i),
    .echo_valid_i   (echo_valid_i),
    .msg_data_i     (msg_data_i),
    .msg_valid_i    (msg_valid_i),
    .msg_ready_o    (msg_ready_o),
    .uart_tx_data_o (uart_tx_data_o),
    .uart_tx_en_o   (uart_tx_en_o),
    .busy_o         (busy_o),
    .echo_overflow_o(echo_overflow_o)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int         at;
    int         sig;
    logic [7:0] val;
  } pin_t;

  pin_t       pins[$];
  logic [7:0] echo_q[$];
  logic [7:0] msg_src[$];
  int         grant_cyc = -1000;
  int         idle_at = 0;
  int         acc_cnt = 0;
  int         acc_seen = 0;
  logic [7:0] pend_byte = 8'h00;
  logic [7:0] shown = 8'h00;
  bit         last_msg = 1'b1;
  bit         ovf = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: a grant at cycle t issues at t+1, keeps busy to t+B-1, rearbitrates at t+B.
  always @(negedge clk_sys) begin : model
    bit e_win;
    bit m_win;
    if (cyc == grant_cyc + 1) shown = pend_byte;
    e_win = 1'b0;
    m_win = 1'b0;
    if (!sys_reset && cyc >= idle_at) begin
      e_win = (echo_q.size() > 0) && (!msg_valid_i || last_msg);
      m_win = msg_valid_i && !e_win;
    end
    chk("tx_en", 8'(uart_tx_en_o), 8'(cyc == grant_cyc + 1));
    chk("tx_data", uart_tx_data_o, shown);
    chk("busy", 8'(busy_o), 8'(cyc > grant_cyc && cyc < grant_cyc + B));
    chk("msg_ready", 8'(msg_ready_o), 8'(m_win));
    chk("overflow", 8'(echo_overflow_o), 8'(ovf));
    foreach (pins[i]) begin
      if (pins[i].at == cyc) begin
        case (pins[i].sig)
          P_EN:    chk("pin_tx_en", 8'(uart_tx_en_o), pins[i].val);
          P_DATA:  chk("pin_tx_data", uart_tx_data_o, pins[i].val);
          P_BUSY:  chk("pin_busy", 8'(busy_o), pins[i].val);
          P_OVF:   chk("pin_overflow", 8'(echo_overflow_o), pins[i].val);
          default: chk("pin_msg_ready", 8'(msg_ready_o), pins[i].val);
        endcase
      end
    end
    if (sys_reset) begin
      echo_q.delete();
      grant_cyc = -1000;
      idle_at   = cyc + 1;
      shown     = 8'h00;
      last_msg  = 1'b1;
      ovf       = 1'b0;
    end else begin
      if (e_win) begin
        pend_byte = echo_q.pop_front();
        last_msg  = 1'b0;
      end else if (m_win) begin
        pend_byte = msg_data_i;
        last_msg  = 1'b1;
        acc_cnt++;
      end
      if (e_win || m_win) begin
        grant_cyc = cyc;
        idle_at   = cyc + B;
      end
      if (echo_valid_i) begin
        if (echo_q.size() < D) echo_q.push_back(echo_data_i);
        else ovf = 1'b1;
      end
    end
  end

  task automatic tick(input bit ev, input logic [7:0] ed);
    @(posedge clk_sys);
    #1;
    sys_reset = 1'b0;
    if (msg_valid_i && acc_cnt != acc_seen) msg_valid_i = 1'b0;
    acc_seen = acc_cnt;
    if (!msg_valid_i && msg_src.size() > 0) begin
      msg_data_i  = msg_src.pop_front();
      msg_valid_i = 1'b1;
    end
    echo_valid_i = ev;
    echo_data_i  = ed;
  endtask

  task automatic rst_tick();
    @(posedge clk_sys);
    #1;
    sys_reset    = 1'b1;
    echo_valid_i = 1'b0;
    msg_valid_i  = 1'b0;
    msg_src.delete();
    acc_seen = acc_cnt;
  endtask

  task automatic pin(input int at, input int sig, input logic [7:0] val);
    pin_t p;
    p.at  = at;
    p.sig = sig;
    p.val = val;
    pins.push_back(p);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00);
  endtask

  initial begin
    int c;
    sys_reset    = 1'b1;
    echo_valid_i = 1'b0;
    echo_data_i  = 8'h00;
    msg_valid_i  = 1'b0;
    msg_data_i   = 8'h00;
    repeat (3) rst_tick();
    idle(5);

    // Single echo byte.
    tick(1'b1, 8'h41);
    c = cyc;
    pin(c + 1, P_EN, 8'h00);
    pin(c + 2, P_EN, 8'h01);
    pin(c + 2, P_DATA, 8'h41);
    pin(c + 2, P_BUSY, 8'h01);
    pin(c + 8, P_BUSY, 8'h01);
    pin(c + 9, P_BUSY, 8'h00);
    idle(12);

    // Back-to-back echo bytes issue exactly B cycles apart.
    tick(1'b1, 8'h31);
    c = cyc;
    tick(1'b1, 8'h32);
    tick(1'b1, 8'h33);
    pin(c + 2, P_DATA, 8'h31);
    pin(c + 9, P_EN, 8'h00);
    pin(c + 10, P_EN, 8'h01);
    pin(c + 10, P_DATA, 8'h32);
    pin(c + 18, P_EN, 8'h01);
    pin(c + 18, P_DATA, 8'h33);
    pin(c + 20, P_OVF, 8'h00);
    idle(25);

    // Tie after reset goes to echo first.
    rst_tick();
    idle(2);
    tick(1'b1, 8'hAA);
    c = cyc;
    msg_src.push_back(8'h55);
    tick(1'b0, 8'h00);
    pin(c + 1, P_RDY, 8'h00);
    pin(c + 2, P_EN, 8'h01);
    pin(c + 2, P_DATA, 8'hAA);
    pin(c + 8, P_RDY, 8'h00);
    pin(c + 9, P_RDY, 8'h01);
    pin(c + 10, P_EN, 8'h01);
    pin(c + 10, P_DATA, 8'h55);
    idle(25);

    // Six echo writes during a message frame: four kept, overflow flagged.
    msg_src.push_back(8'h70);
    tick(1'b0, 8'h00);
    c = cyc;
    for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'hE0 + i));
    pin(c + 1, P_DATA, 8'h70);
    pin(c + 5, P_OVF, 8'h00);
    pin(c + 6, P_OVF, 8'h01);
    pin(c + 9, P_DATA, 8'hE0);
    pin(c + 17, P_DATA, 8'hE1);
    pin(c + 25, P_DATA, 8'hE2);
    pin(c + 33, P_EN, 8'h01);
    pin(c + 33, P_DATA, 8'hE3);
    pin(c + 41, P_EN, 8'h00);
    idle(45);

    // Full FIFO with pop and write in the same idle cycle.
    rst_tick();
    idle(3);
    msg_src.push_back(8'h71);
    tick(1'b0, 8'h00);
    c = cyc;
    for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'hF0 + i));
    idle(3);
    tick(1'b1, 8'hF4);
    pin(c + 9, P_DATA, 8'hF0);
    pin(c + 9, P_OVF, 8'h00);
    pin(c + 12, P_OVF, 8'h00);
    pin(c + 33, P_DATA, 8'hF3);
    pin(c + 41, P_EN, 8'h01);
    pin(c + 41, P_DATA, 8'hF4);
    idle(45);

    // Reset during GAP with two bytes queued.
    tick(1'b1, 8'hA0);
    c = cyc;
    tick(1'b1, 8'hA1);
    tick(1'b1, 8'hA2);
    idle(2);
    rst_tick();
    pin(c + 2, P_DATA, 8'hA0);
    pin(c + 5, P_BUSY, 8'h01);
    pin(c + 6, P_EN, 8'h00);
    pin(c + 6, P_DATA, 8'h00);
    pin(c + 6, P_BUSY, 8'h00);
    pin(c + 6, P_OVF, 8'h00);
    pin(c + 10, P_EN, 8'h00);
    pin(c + 18, P_EN, 8'h00);
    idle(20);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (!msg_valid_i && msg_src.size() == 0 && $urandom_range(0, 19) == 0)
        msg_src.push_back(8'($urandom));
      if ($urandom_range(0, 399) == 0) rst_tick();
      else tick($urandom_range(0, 9) < 2, 8'($urandom));
    end
    idle(20);
    @(negedge clk_sys);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares the single `uart_tx_path` transmitter between two byte sources: the receive-echo stream (`uart_rx_data_o`/`uart_rx_done`) and a message source that returns status text from `uart_control`. Echo bytes are buffered in a small FIFO because the receiver cannot be stalled. Message bytes use a valid/ready handshake. The scheduler paces issue to one byte per UART frame time, because `uart_tx_path` has no busy output. It sits between the RX path / control logic and `uart_tx_path` in `usb_seg_top`.

## Interface
- `BYTE_CYCLES`, default 52080: clk_sys cycles per transmitted frame (10 bits at 9600 baud, 50 MHz). Must be ≥ 3.
- `ECHO_DEPTH`, default 4: echo FIFO depth. Must be a power of 2, ≥ 2.
- `clk_sys`  in  1  sole clock; all logic on rising edge.
- `sys_reset`  in  1  synchronous, active-high reset.
- `echo_data_i`  in  8  echo byte.
- `echo_valid_i`  in  1  one-cycle write strobe for `echo_data_i`.
- `msg_data_i`  in  8  message byte.
- `msg_valid_i`  in  1  message byte offered; held until accepted.
- `msg_ready_o`  out  1  message byte accepted this cycle when `msg_valid_i` is also high.
- `uart_tx_data_o`  out  8  byte to `uart_tx_path`.
- `uart_tx_en_o`  out  1  one-cycle start pulse to `uart_tx_path`.
- `busy_o`  out  1  high while a frame is in flight (SEND or GAP state).
- `echo_overflow_o`  out  1  sticky; an echo byte was dropped.

## Operation
- States:
  - IDLE: arbitrate.
  - SEND: one cycle; `uart_tx_en_o`=1 and `uart_tx_data_o` = the granted byte.
  - GAP: a down-counter runs from BYTE_CYCLES−2 to 0, then the block returns to IDLE.
- Request rules in IDLE:
  - Echo requests when the FIFO is non-empty.
  - Message requests when `msg_valid_i`=1.
- Arbitration is round-robin on `last_grant`:
  - Both requesting: the source not granted last time wins.
  - One requesting: that source wins.
  - On a grant, the block latches the byte into the output register, sets `last_grant`, and moves to SEND.
- `msg_ready_o` is combinational. It is 1 only in IDLE when the message source wins arbitration this cycle.
- Echo FIFO write: if `echo_valid_i` and not full, write.
- Echo FIFO overflow: if `echo_valid_i` and full, with no pop in the same cycle, drop the byte and set `echo_overflow_o`=1. It clears only on reset.
- Full FIFO with a simultaneous pop (echo grant) and write: both take effect. Count is unchanged and no overflow is flagged.
- Empty FIFO with a simultaneous write: the byte is not visible to the arbiter until the next cycle.
- FIFO pointers are log2(ECHO_DEPTH)+1 bits and wrap naturally. Full/empty come from MSB comparison.
- `uart_tx_data_o` holds its last value outside SEND.

## Timing
- Reset values:
  - State = IDLE, counter = 0.
  - FIFO empty (pointers 0).
  - `last_grant` = MSG, so echo wins the first tie.
  - `uart_tx_en_o`=0, `uart_tx_data_o`=8'h00, `busy_o`=0, `msg_ready_o`=0, `echo_overflow_o`=0.
- Latency:
  - Grant in IDLE at cycle N gives `uart_tx_en_o`=1 at cycle N+1.
  - An echo byte written into an empty FIFO at cycle N is granted at N+1 and appears at N+2.
- Issue spacing: consecutive `uart_tx_en_o` pulses are exactly BYTE_CYCLES cycles apart under continuous demand, and never fewer.
- `busy_o`=1 from SEND through the last GAP cycle.
- Reset asserted mid-frame: return to IDLE next edge, flush the FIFO, clear overflow. An already-started `uart_tx_path` frame is not tracked.
- Message handshake: a message byte is consumed only on the cycle `msg_valid_i & msg_ready_o`=1. The source keeps data stable while valid and not ready.

## Structure
- Package `uart_sched_pkg` holds:
  - the state enum (IDLE, SEND, GAP);
  - the grant enum (GRANT_ECHO, GRANT_MSG);
  - a width function for the counter, $clog2(BYTE_CYCLES).
- Sub-module `byte_fifo`:
  - parameterised depth, 8-bit data;
  - `wr_en`, `rd_en`, `full`, `empty`, first-word-fall-through `rd_data`;
  - same clock/reset.
- Top-level integration in `usb_seg_top`:
  - echo inputs are `uart_rx_data_o`/`uart_rx_done`;
  - outputs drive `uart_tx_path`.

## Test plan
All scenarios run with BYTE_CYCLES=8, ECHO_DEPTH=4.
- Single echo: write 8'h41 at cycle 10 → `uart_tx_en_o` pulse with 8'h41 at cycle 12; `busy_o` high cycles 12–18.
- Back-to-back: echo writes 8'h31, 8'h32, 8'h33 on consecutive cycles → three pulses exactly 8 cycles apart, in order, no overflow.
- Tie after reset: echo 8'hAA and message 8'h55 pending together → AA first, then 55 eight cycles later. `msg_ready_o` pulses once, in the IDLE cycle before the 55 SEND.
- Overflow: 6 echo writes while a message frame is in flight → 4 bytes retained and sent in order, `echo_overflow_o`=1 after the 5th write.
- Full FIFO, simultaneous pop and write in IDLE → no overflow, the new byte is sent last.
- Reset during GAP with 2 bytes queued → next cycle all outputs at reset values, FIFO empty, no further `uart_tx_en_o` pulses.
